// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side sequencer for the CPU register file.
// Results arriving from execute/memory (destination index + data) are
// buffered in a DEPTH-entry FIFO. Each entry is replayed to the register
// file as IDLE -> SETUP -> STROBE -> HOLD. This keeps wr/wd stable for a
// full cycle before and after every rising edge of regwrite.
// Optional feature macro: REGFILE_WB_HAZARD_EN adds read-hazard
// comparators (chk_rr1/chk_rr2 -> hazard1/hazard2) for the decode stage.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic [DATA_W-1:0]      in_data,
  output logic [ADDR_W-1:0]      wr,
  output logic [DATA_W-1:0]      wd,
  output logic                   regwrite,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
`ifdef REGFILE_WB_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0]      chk_rr1,
  input  logic [ADDR_W-1:0]      chk_rr2,
  output logic                   hazard1,
  output logic                   hazard2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // FIFO storage and pointers
  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // Sequencer state and registered write-port outputs
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              regwrite_q, regwrite_d;

  // Handshake qualifiers
  logic              ready_c;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  // Handshake: ready depends only on the registered count, so a pop in the
  // same cycle never opens room for a push into a full FIFO. x0 results
  // complete the handshake but are dropped, so x0 is never written.
  always_comb begin
    ready_c   = (count_q < CNT_W'(DEPTH));
    accept    = in_valid && ready_c;
    push      = accept && (in_rd != '0);
    pop       = (state_q == ST_IDLE) && (count_q != '0);
    head_rd   = fifo_rd_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];
  end

  // FIFO next-state: write at the tail on push, advance head on pop.
  // Pointers are PTR_W wide, so they wrap modulo DEPTH naturally.
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = in_rd;
      fifo_data_d[wr_ptr_q] = in_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Write sequencer: wr/wd are only loaded on IDLE->SETUP, and regwrite is
  // high only while in STROBE, giving a low cycle on both sides of the edge.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    wd_d       = wd_q;
    regwrite_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          wr_d    = head_rd;
          wd_d    = head_data;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        regwrite_d = 1'b1;
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset flushes the FIFO and drops regwrite on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      wd_q       <= '0;
      regwrite_q <= 1'b0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wr_q        <= wr_d;
      wd_q        <= wd_d;
      regwrite_q  <= regwrite_d;
    end
  end

  // Output mapping; regwrite comes straight from its flop so it cannot glitch
  always_comb begin
    in_ready = ready_c;
    wr       = wr_q;
    wd       = wd_q;
    regwrite = regwrite_q;
    count    = count_q;
    empty    = (count_q == '0) && (state_q == ST_IDLE);
  end

`ifdef REGFILE_WB_HAZARD_EN
  logic [DEPTH-1:0] entry_valid;
  logic [PTR_W-1:0] entry_offset;
  logic             hazard1_c;
  logic             hazard2_c;

  // An entry is live when its distance from the head is below count
  always_comb begin
    entry_valid  = '0;
    entry_offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_offset   = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = (CNT_W'(entry_offset) < count_q);
    end
  end

  // A read is stale if its register is queued or loaded but not yet strobed
  always_comb begin
    hazard1_c = (chk_rr1 != '0) && (state_q == ST_SETUP) && (wr_q == chk_rr1);
    hazard2_c = (chk_rr2 != '0) && (state_q == ST_SETUP) && (wr_q == chk_rr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (chk_rr1 != '0) && (fifo_rd_q[i] == chk_rr1)) begin
        hazard1_c = 1'b1;
      end
      if (entry_valid[i] && (chk_rr2 != '0) && (fifo_rd_q[i] == chk_rr2)) begin
        hazard2_c = 1'b1;
      end
    end
    hazard1 = hazard1_c;
    hazard2 = hazard2_c;
  end
`endif

endmodule
